rule_pg_update_ctrl: RTL and testbench

Sequences run-time updates of the port_group rule-to-port-group tables. Host register writes are collected into table entries and queued. The block then closes the metadata gate in front of port_group at a packet boundary and waits for the rule_unit lookup pipeline to drain. Only then does it drive the table write port, so writes never collide with in-flight lookups on URAM port A. It sits between the metadata source and port_group and owns port_group's wr_data/wr_addr/wr_en.

---
 rtl/rule_pg_update_ctrl_if.sv | 29 ++
 rtl/rule_pg_update_ctrl.sv | 149 ++++++++++++++
 tb/tb_rule_pg_update_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rule_pg_update_ctrl_if.sv
// Metadata gate, host register and table-write signals for rule_pg_update_ctrl.
interface rule_pg_update_ctrl_if #(
  parameter int RULE_PG_WIDTH = 32,
  parameter int RULE_AWIDTH   = 13
);
  logic                         up_meta_valid;
  logic                         up_meta_ready;
  logic                         pg_meta_valid;
  logic                         pg_meta_ready;
  logic                         reg_wr_en;
  logic [1:0]                   reg_wr_addr;
  logic [31:0]                  reg_wr_data;
  logic                         reg_rd_addr;
  logic [31:0]                  reg_rd_data;
  logic [2*RULE_PG_WIDTH-1:0]   tbl_wr_data;
  logic [RULE_AWIDTH-2:0]       tbl_wr_addr;
  logic                         tbl_wr_en;
  logic                         busy;

  modport slave (
    input  up_meta_valid, pg_meta_ready, reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_addr,
    output up_meta_ready, pg_meta_valid, reg_rd_data, tbl_wr_data, tbl_wr_addr, tbl_wr_en, busy
  );

  modport master (
    output up_meta_valid, pg_meta_ready, reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_addr,
    input  up_meta_ready, pg_meta_valid, reg_rd_data, tbl_wr_data, tbl_wr_addr, tbl_wr_en, busy
  );
endinterface

// File: rtl/rule_pg_update_ctrl.sv
// Queues host rule->port-group table updates and writes them into port_group
// only after the metadata gate is closed and the lookup pipeline has drained.
module rule_pg_update_ctrl #(
  parameter int RULE_PG_WIDTH = 32,
  parameter int RULE_AWIDTH   = 13,
  parameter int DRAIN_CYCLES  = 20,
  parameter int FIFO_DEPTH    = 4
) (
  input logic                 clk,
  input logic                 rst,
  rule_pg_update_ctrl_if.slave bus
);
  localparam int DW = 2*RULE_PG_WIDTH;
  localparam int AW = RULE_AWIDTH-1;
  localparam int EW = AW+DW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(DRAIN_CYCLES+1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_GATE = 4'd1, S_DRAIN = 4'd2,
    S_WRITE = 4'd3, S_SETTLE = 4'd4, S_HELD = 4'd5
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   tmr, tmr_nxt;
  logic [63:0]     staging;
  logic            hold, ovf, in_flight;
  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     fifo_cnt;
  logic            fifo_empty, fifo_full;
  logic            push_req, push, pop, pg_valid;
  logic [31:0]     upd_cnt;
  logic [31:0]     status;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
  assign push_req   = bus.reg_wr_en && (bus.reg_wr_addr == 2'd2);
  // A full queue still accepts a commit when an entry leaves the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  // Pop whenever the FSM will be in WRITE next cycle, so tbl_wr_en (registered)
  // lines up with the first WRITE cycle.
  assign pop        = !fifo_empty && (state_nxt == S_WRITE);

  assign pg_valid          = bus.up_meta_valid && ((state == S_IDLE) || in_flight);
  assign bus.pg_meta_valid = pg_valid;
  assign bus.up_meta_ready = bus.pg_meta_ready;
  assign bus.busy          = (state != S_IDLE);
  assign status = {16'b0, 8'(fifo_cnt), ovf, hold, in_flight, (state != S_IDLE), state};

  // Host register writes: staging halves, overflow flag, hold/ovf control.
  always_ff @(posedge clk) begin
    if (rst) begin
      staging <= '0;
      hold    <= 1'b0;
      ovf     <= 1'b0;
    end else if (bus.reg_wr_en) begin
      case (bus.reg_wr_addr)
        2'd0: staging[31:0]  <= bus.reg_wr_data;
        2'd1: staging[63:32] <= bus.reg_wr_data;
        2'd2: if (!push) ovf <= 1'b1;
        default: begin
          hold <= bus.reg_wr_data[0];
          if (bus.reg_wr_data[1]) ovf <= 1'b0;
        end
      endcase
    end
  end

  // Pending-entry storage (no reset needed, guarded by the pointers).
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.reg_wr_data[AW-1:0], staging[DW-1:0]};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Tracks a presented-but-unaccepted packet so its valid is never withdrawn.
  always_ff @(posedge clk) begin
    if (rst)                                in_flight <= 1'b0;
    else if (pg_valid && bus.pg_meta_ready) in_flight <= 1'b0;
    else if (pg_valid)                      in_flight <= 1'b1;
  end

  // FSM state and shared drain/settle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next-state: gate, drain, burst write, settle, optional batch hold.
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    case (state)
      S_IDLE:   if (!fifo_empty || hold) state_nxt = S_GATE;
      S_GATE:   if (!in_flight) begin
                  state_nxt = S_DRAIN;
                  tmr_nxt   = CW'(DRAIN_CYCLES-1);
                end
      S_DRAIN:  if (tmr == '0) state_nxt = S_WRITE;
                else           tmr_nxt   = tmr - 1'b1;
      S_WRITE:  if (fifo_empty) begin
                  state_nxt = S_SETTLE;
                  tmr_nxt   = CW'(1);
                end
      S_SETTLE: if (tmr == '0) state_nxt = hold ? S_HELD : S_IDLE;
                else           tmr_nxt   = tmr - 1'b1;
      S_HELD:   if (!fifo_empty) state_nxt = S_WRITE;
                else if (!hold)  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Registered table write port, update counter and register read-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.tbl_wr_en   <= 1'b0;
      bus.tbl_wr_addr <= '0;
      bus.tbl_wr_data <= '0;
      bus.reg_rd_data <= '0;
      upd_cnt         <= '0;
    end else begin
      bus.tbl_wr_en <= pop;
      if (pop) {bus.tbl_wr_addr, bus.tbl_wr_data} <= fifo_mem[rd_ptr];
      if (bus.tbl_wr_en) upd_cnt <= upd_cnt + 32'd1;
      bus.reg_rd_data <= bus.reg_rd_addr ? upd_cnt : status;
    end
  end
endmodule

// File: tb/tb_rule_pg_update_ctrl.sv
// Directed bench for rule_pg_update_ctrl: table of single updates plus
// hand-written in-flight, overflow, batch and reset sequences.
module tb_rule_pg_update_ctrl;
  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  rule_pg_update_ctrl_if bus();

  rule_pg_update_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic        wr_d0;
    logic [31:0] d0;
    logic        wr_d1;
    logic [31:0] d1;
    logic [31:0] commit;
    logic [11:0] exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_wr_en   = 1'b1;
    bus.reg_wr_addr = a;
    bus.reg_wr_data = d;
    #1;
  endtask

  task automatic rd(input logic a, output logic [31:0] v);
    @(negedge clk);
    bus.reg_wr_en   = 1'b0;
    bus.reg_rd_addr = a;
    #1;
    @(negedge clk);
    #1;
    v = bus.reg_rd_data;
  endtask

  initial begin
    logic [31:0] v;
    logic [11:0] ga;
    logic [63:0] gd;
    int          n, first, last, bad;
    logic [11:0] addrs [8];
    int          cyc [8];

    vt[0] = '{1'b1, 32'h1111_2222, 1'b1, 32'h3333_4444, 32'h0000_0005, 12'h005, 64'h3333_4444_1111_2222};
    vt[1] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D, 32'hFFFF_FFFF, 12'hFFF, 64'hCAFE_F00D_DEAD_BEEF};
    vt[2] = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h0000_1000, 12'h000, 64'hCAFE_F00D_DEAD_BEEF};
    vt[3] = '{1'b1, 32'h0,         1'b1, 32'hFFFF_FFFF, 32'h0000_0ABC, 12'hABC, 64'hFFFF_FFFF_0000_0000};

    // Reset state
    rst = 1'b1;
    bus.up_meta_valid = 1'b1;
    bus.pg_meta_ready = 1'b1;
    bus.reg_wr_en = 1'b0; bus.reg_wr_addr = '0; bus.reg_wr_data = '0; bus.reg_rd_addr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pg_valid_follows", {63'b0, bus.pg_meta_valid}, 64'd1);
    chk("rst_up_ready_pass", {63'b0, bus.up_meta_ready}, 64'd1);
    chk("rst_wr_en", {63'b0, bus.tbl_wr_en}, 64'd0);
    chk("rst_wr_addr", {52'b0, bus.tbl_wr_addr}, 64'd0);
    chk("rst_wr_data", bus.tbl_wr_data, 64'd0);
    chk("rst_rd_data", {32'b0, bus.reg_rd_data}, 64'd0);
    chk("rst_busy", {63'b0, bus.busy}, 64'd0);
    bus.up_meta_valid = 1'b0;
    bus.pg_meta_ready = 1'b0;
    #1;
    chk("rst_pg_valid_low", {63'b0, bus.pg_meta_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(1'b0, v); chk("rst_status", {32'b0, v}, 64'd0);
    rd(1'b1, v); chk("rst_update_cnt", {32'b0, v}, 64'd0);

    // Single-update vectors, no traffic: write lands at t+23, IDLE at t+26
    for (int i = 0; i < 4; i++) begin
      if (vt[i].wr_d0) wr(2'd0, vt[i].d0);
      if (vt[i].wr_d1) wr(2'd1, vt[i].d1);
      wr(2'd2, vt[i].commit);
      n = 0; first = 0; ga = '0; gd = '0;
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        bus.reg_wr_en = 1'b0;
        #1;
        if (bus.tbl_wr_en) begin
          n++;
          if (n == 1) begin first = k; ga = bus.tbl_wr_addr; gd = bus.tbl_wr_data; end
        end
        if (k == 2)  chk($sformatf("v%0d_busy_gate", i), {63'b0, bus.busy}, 64'd1);
        if (k == 25) chk($sformatf("v%0d_busy_settle", i), {63'b0, bus.busy}, 64'd1);
        if (k == 26) chk($sformatf("v%0d_idle", i), {63'b0, bus.busy}, 64'd0);
      end
      chk($sformatf("v%0d_wr_cycle", i), 64'(first), 64'd23);
      chk($sformatf("v%0d_wr_count", i), 64'(n), 64'd1);
      chk($sformatf("v%0d_wr_addr", i), {52'b0, ga}, {52'b0, vt[i].exp_addr});
      chk($sformatf("v%0d_wr_data", i), gd, vt[i].exp_data);
      rd(1'b1, v);
      chk($sformatf("v%0d_update_cnt", i), {32'b0, v}, 64'(i+1));
    end

    // Packet in flight: gate held open until the ready pulse
    @(negedge clk);
    bus.reg_wr_en = 1'b0;
    bus.up_meta_valid = 1'b1;
    #1;
    chk("pkt_open", {63'b0, bus.pg_meta_valid}, 64'd1);
    wr(2'd2, 32'h0000_0007);
    n = 0; first = 0; bad = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      bus.reg_wr_en = 1'b0;
      bus.pg_meta_ready = (k == 6) || (k == 33);
      if (k == 34) bus.up_meta_valid = 1'b0;
      #1;
      if (k <= 6 && !bus.pg_meta_valid) bad++;
      if (k == 7)  chk("pkt_gate_closed", {63'b0, bus.pg_meta_valid}, 64'd0);
      if (k == 30) chk("pkt_settle_closed", {63'b0, bus.pg_meta_valid}, 64'd0);
      if (k == 31) chk("pkt_reopen", {63'b0, bus.pg_meta_valid}, 64'd1);
      if (bus.tbl_wr_en) begin
        n++;
        if (n == 1) begin first = k; ga = bus.tbl_wr_addr; end
      end
    end
    chk("pkt_valid_kept", 64'(bad), 64'd0);
    chk("pkt_wr_cycle", 64'(first), 64'd28);
    chk("pkt_wr_count", 64'(n), 64'd1);
    chk("pkt_wr_addr", {52'b0, ga}, 64'h7);

    // Overflow: hold starts the drain, 5 back-to-back commits into depth 4
    wr(2'd3, 32'd1);
    n = 0; first = 0; last = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      bus.reg_wr_en = 1'b0;
      bus.reg_rd_addr = 1'b0;
      if (k == 5) begin
        bus.reg_wr_en = 1'b1; bus.reg_wr_addr = 2'd3; bus.reg_wr_data = 32'd0;
      end else if (k >= 6 && k <= 10) begin
        bus.reg_wr_en = 1'b1; bus.reg_wr_addr = 2'd2; bus.reg_wr_data = 32'(k-5);
      end
      #1;
      if (k == 12) chk("ovf_status_drain", {32'b0, bus.reg_rd_data}, 64'h492);
      if (bus.tbl_wr_en) begin
        if (n == 0) first = k;
        if (n < 8) addrs[n] = bus.tbl_wr_addr;
        last = k;
        n++;
      end
    end
    chk("ovf_wr_count", 64'(n), 64'd4);
    chk("ovf_first", 64'(first), 64'd23);
    chk("ovf_last", 64'(last), 64'd26);
    for (int j = 0; j < 4; j++)
      chk($sformatf("ovf_addr%0d", j), {52'b0, addrs[j]}, 64'(j+1));
    rd(1'b0, v); chk("ovf_sticky", {32'b0, v}, 64'h80);
    wr(2'd3, 32'd2);
    rd(1'b0, v); chk("ovf_cleared", {32'b0, v}, 64'h0);
    rd(1'b1, v); chk("ovf_update_cnt", {32'b0, v}, 64'd9);

    // Batch: one drain, then each commit written 2 cycles later from HELD
    wr(2'd3, 32'd1);
    n = 0; bad = 0;
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk);
      bus.reg_wr_en = 1'b0;
      bus.reg_rd_addr = 1'b0;
      bus.up_meta_valid = (k >= 28) && (k <= 63);
      bus.pg_meta_ready = (k == 63);
      if (k == 30 || k == 40 || k == 50) begin
        bus.reg_wr_en = 1'b1; bus.reg_wr_addr = 2'd2; bus.reg_wr_data = 32'h10 + 32'((k-30)/10);
      end else if (k == 60) begin
        bus.reg_wr_en = 1'b1; bus.reg_wr_addr = 2'd3; bus.reg_wr_data = 32'd0;
      end
      #1;
      if (k == 29) chk("batch_status_held", {32'b0, bus.reg_rd_data}, 64'h55);
      if (k >= 28 && k <= 61 && bus.pg_meta_valid) bad++;
      if (k == 61) chk("batch_busy_held", {63'b0, bus.busy}, 64'd1);
      if (k == 62) begin
        chk("batch_idle", {63'b0, bus.busy}, 64'd0);
        chk("batch_pg_valid_follows", {63'b0, bus.pg_meta_valid}, 64'd1);
      end
      if (bus.tbl_wr_en) begin
        if (n < 8) begin cyc[n] = k; addrs[n] = bus.tbl_wr_addr; end
        n++;
      end
    end
    chk("batch_gate_closed", 64'(bad), 64'd0);
    chk("batch_wr_count", 64'(n), 64'd3);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("batch_cycle%0d", j), 64'(cyc[j]), 64'(32 + 10*j));
      chk($sformatf("batch_addr%0d", j), {52'b0, addrs[j]}, 64'(16 + j));
    end
    rd(1'b1, v); chk("batch_update_cnt", {32'b0, v}, 64'd12);

    // Reset during WRITE with two entries still queued
    wr(2'd2, 32'h21);
    wr(2'd2, 32'h22);
    wr(2'd2, 32'h23);
    n = 0;
    for (int k = 3; k <= 45; k++) begin
      @(negedge clk);
      bus.reg_wr_en = 1'b0;
      bus.reg_rd_addr = 1'b0;
      rst = (k == 23) || (k == 24);
      #1;
      if (k == 23) begin
        chk("rstw_wr_before", {63'b0, bus.tbl_wr_en}, 64'd1);
        chk("rstw_addr_before", {52'b0, bus.tbl_wr_addr}, 64'h21);
      end
      if (k >= 24 && bus.tbl_wr_en) n++;
      if (k == 24) chk("rstw_rd_data", {32'b0, bus.reg_rd_data}, 64'd0);
      if (k == 26) begin
        chk("rstw_status", {32'b0, bus.reg_rd_data}, 64'd0);
        chk("rstw_busy", {63'b0, bus.busy}, 64'd0);
      end
    end
    chk("rstw_no_writes", 64'(n), 64'd0);
    rd(1'b1, v); chk("rstw_update_cnt", {32'b0, v}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
